// File: rtl/random_perm_gen_pkg.sv
// Shared constants and types for the free-running permutation shuffler.
// Also provides the scaled-index helper used by the swap datapath.
package random_perm_gen_pkg;

  localparam int N_ENT = 16;
  localparam int ENT_W = 4;

  localparam logic [63:0] IDENTITY_PERM = 64'hFEDCBA9876543210;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;
  localparam logic [15:0] DEFAULT_POLY  = 16'hB400;

  typedef logic [ENT_W-1:0] ent_t;

  // Upper bits of rnd*(j+1) land in 0..j; 255*16 fits in 12 bits.
  function automatic ent_t pick_idx(
    input logic [7:0] rnd,
    input ent_t       j
  );
    logic [4:0]  span;
    logic [12:0] prod;
    span = {1'b0, j} + 5'd1;
    prod = {5'd0, rnd} * {8'd0, span};
    return prod[11:8];
  endfunction

endpackage

// File: rtl/random_perm_gen_lfsr.sv
// 16-bit Galois LFSR stepping every clock.
// A zero seed would lock up, so it is replaced by the default seed.
module random_perm_gen_lfsr
  import random_perm_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter logic [15:0] POLY = DEFAULT_POLY
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);

  localparam logic [15:0] INIT =
    (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ POLY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/random_perm_gen.sv
// Incremental Fisher-Yates shuffler: one swap per clock, 15-cycle passes.
// RANDOM_PERM_GEN_SNAPSHOT_EN: output only updates at the end of each pass.
module random_perm_gen
  import random_perm_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter logic [15:0] POLY = DEFAULT_POLY
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] seq_all
);

  logic [15:0] lfsr;

  logic [N_ENT-1:0][ENT_W-1:0] perm_q;
  logic [N_ENT-1:0][ENT_W-1:0] perm_d;
  ent_t j_q;
  ent_t j_d;
  ent_t r;

  random_perm_gen_lfsr #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .lfsr_o (lfsr)
  );

  always_comb begin
    r         = pick_idx(lfsr[7:0], j_q);
    perm_d    = perm_q;
    perm_d[j_q] = perm_q[r];
    perm_d[r]   = perm_q[j_q];
    j_d       = (j_q == ent_t'(1)) ? ent_t'(15) : j_q - ent_t'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perm_q <= IDENTITY_PERM;
      j_q    <= ent_t'(15);
    end else begin
      perm_q <= perm_d;
      j_q    <= j_d;
    end
  end

`ifdef RANDOM_PERM_GEN_SNAPSHOT_EN
  logic [63:0] snap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q <= IDENTITY_PERM;
    end else if (j_q == ent_t'(1)) begin
      snap_q <= perm_d;
    end
  end

  assign seq_all = snap_q;
`else
  assign seq_all = perm_q;
`endif

endmodule

// File: tb/tb_random_perm_gen.sv
// Directed and model-based checks for random_perm_gen.
// Covers reset, first swaps, long-run invariant, mid-pass reset, zero seed.
module tb_random_perm_gen;

  logic        clk;
  logic        rst;
  logic [63:0] seq_all;
  logic [63:0] seq_all0;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] ID = 64'hFEDCBA9876543210;

  random_perm_gen dut (
    .clk     (clk),
    .rst     (rst),
    .seq_all (seq_all)
  );

  random_perm_gen #(.SEED(16'h0000)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .seq_all (seq_all0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] m_lfsr;
  int          m_perm [16];
  int          m_j;
  logic [63:0] m_snap;

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = 4'(m_perm[i]);
    return v;
  endfunction

  function automatic logic [63:0] m_seq();
`ifdef RANDOM_PERM_GEN_SNAPSHOT_EN
    return m_snap;
`else
    return m_pack();
`endif
  endfunction

  task automatic m_reset();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 16; i++) m_perm[i] = i;
    m_j    = 15;
    m_snap = ID;
  endtask

  task automatic m_step();
    int r;
    int t;
    r = (int'(m_lfsr[7:0]) * (m_j + 1)) / 256;
    t = m_perm[m_j];
    m_perm[m_j] = m_perm[r];
    m_perm[r] = t;
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else m_lfsr = m_lfsr >> 1;
    if (m_j == 1) begin
      m_snap = m_pack();
      m_j = 15;
    end else begin
      m_j = m_j - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic bit distinct(input logic [63:0] v);
    logic [15:0] seen;
    seen = '0;
    for (int i = 0; i < 16; i++) seen[v[4*i +: 4]] = 1'b1;
    return seen == 16'hFFFF;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (seq_all !== ID) begin
      errors++;
      $display("FAIL reset_seq got=%h exp=%h", seq_all, ID);
    end
    checks++;
    if (dut.j_q !== 4'd15) begin
      errors++;
      $display("FAIL reset_j got=%0d exp=15", dut.j_q);
    end
    checks++;
    if (dut.lfsr !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_lfsr got=%h exp=ace1", dut.lfsr);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_first_edges(input string tag);
    logic [63:0] e1;
    logic [63:0] e2;
`ifdef RANDOM_PERM_GEN_SNAPSHOT_EN
    e1 = ID;
    e2 = ID;
`else
    e1 = 64'hEFDCBA9876543210;
    e2 = 64'hE6DCBA987F543210;
`endif
    tick();
    checks++;
    if (seq_all !== e1) begin
      errors++;
      $display("FAIL %s_edge1 got=%h exp=%h", tag, seq_all, e1);
    end
    checks++;
    if (dut.lfsr !== 16'hE270) begin
      errors++;
      $display("FAIL %s_lfsr1 got=%h exp=e270", tag, dut.lfsr);
    end
    tick();
    checks++;
    if (seq_all !== e2) begin
      errors++;
      $display("FAIL %s_edge2 got=%h exp=%h", tag, seq_all, e2);
    end
  endtask

  task automatic test_long_run();
    int changes;
    logic [63:0] prev;
    do_reset();
    changes = 0;
    prev = seq_all;
    for (int c = 1; c <= 10000; c++) begin
      tick();
      checks++;
      if (seq_all !== m_seq()) begin
        errors++;
        $display("FAIL model c=%0d got=%h exp=%h", c, seq_all, m_seq());
      end
      checks++;
      if (!distinct(seq_all)) begin
        errors++;
        $display("FAIL distinct c=%0d got=%h", c, seq_all);
      end
      checks++;
      if (dut.j_q !== 4'(m_j)) begin
        errors++;
        $display("FAIL j_seq c=%0d got=%0d exp=%0d", c, dut.j_q, m_j);
      end
      if (seq_all !== prev) changes++;
      prev = seq_all;
    end
`ifdef RANDOM_PERM_GEN_SNAPSHOT_EN
    checks++;
    if (changes > 10000 / 15) begin
      errors++;
      $display("FAIL snap_rate got=%0d exp<=%0d", changes, 10000 / 15);
    end
`else
    checks++;
    if (changes < 5000) begin
      errors++;
      $display("FAIL change_rate got=%0d exp>=5000", changes);
    end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (37) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (seq_all !== ID) begin
      errors++;
      $display("FAIL mid_reset_seq got=%h exp=%h", seq_all, ID);
    end
    checks++;
    if (dut.j_q !== 4'd15) begin
      errors++;
      $display("FAIL mid_reset_j got=%0d exp=15", dut.j_q);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    test_first_edges("after_reset");
  endtask

  task automatic test_zero_seed();
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      tick();
      checks++;
      if (seq_all0 !== seq_all) begin
        errors++;
        $display("FAIL zero_seed c=%0d got=%h exp=%h", c, seq_all0, seq_all);
      end
    end
  endtask

  task automatic test_snapshot_edges();
`ifdef RANDOM_PERM_GEN_SNAPSHOT_EN
    logic [63:0] prev;
    do_reset();
    prev = seq_all;
    for (int c = 1; c <= 45; c++) begin
      tick();
      checks++;
      if ((seq_all !== prev) !== (c % 15 == 0)) begin
        errors++;
        $display("FAIL snap_edge c=%0d got=%h prev=%h", c, seq_all, prev);
      end
      prev = seq_all;
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    #2;
    test_reset();
    test_first_edges("first");
    test_long_run();
    test_mid_reset();
    test_zero_seed();
    test_snapshot_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/random_perm_gen.md
Name: random_perm_gen

Overview:
- Free-running hardware shuffler.
- Continuously produces a pseudo-random permutation of the 16 values 0..15, packed as sixteen 4-bit entries on a 64-bit bus.
- Randomness comes from an internal 16-bit Galois LFSR driving an incremental Fisher-Yates shuffle, one swap per clock.
- Feeds consumers that need a shuffled index order (test pattern generators, randomized schedulers).

Parameters:
- SEED, 16'hACE1: LFSR reset value. SEED==0 is illegal; the RTL substitutes 16'hACE1 for it.
- POLY, 16'hB400: Galois feedback mask, x^16+x^14+x^13+x^11+1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous reset, active-low (asserted when 0).
- seq_all, output, 64: permutation; entry i = seq_all[4i+3:4i], i=0..15.

Behaviour:
- State:
  - perm[0:15], 4 bits each.
  - lfsr, 16 bits.
  - j, 4-bit pass index.
- Reset (rst==0, asynchronous):
  - perm[i]=i, so seq_all=64'hFEDCBA9876543210.
  - lfsr=SEED.
  - j=15.
  - Reset asserted mid-pass aborts the pass immediately and restores this state.
- Each rising clk with rst==1:
  - r = (lfsr[7:0] * (j+1)) >> 8. This is 8x5-bit unsigned multiply, keeping the upper bits, so r is always in 0..j.
  - Swap perm[j] and perm[r]. When r==j, no change.
  - LFSR step: if lfsr[0], lfsr <= (lfsr>>1)^POLY; else lfsr <= lfsr>>1.
  - j <= (j==1) ? 15 : j-1. One pass is 15 cycles, and passes repeat forever.
- Invariant: seq_all is a valid permutation at every cycle (16 distinct nibbles).
- Latency: a swap is visible on seq_all the cycle after the edge that performs it (registered output, no combinational path from inputs).
- No handshake. The output is always valid and changes every cycle unless r==j.

Optional Feature:
- Macro RANDOM_PERM_GEN_SNAPSHOT_EN.
- Defined:
  - seq_all is driven from a separate 64-bit snapshot register.
  - Snapshot resets to 64'hFEDCBA9876543210.
  - Snapshot loads the post-swap working array on the edge where j==1, i.e. at the end of each 15-swap pass.
  - seq_all therefore changes once every 15 cycles, and always presents a fully shuffled pass.
- Undefined: seq_all mirrors the working array every cycle, as described above.

Decomposition:
- Package random_perm_gen_pkg holds:
  - N_ENT=16, ENT_W=4;
  - IDENTITY_PERM=64'hFEDCBA9876543210;
  - DEFAULT_SEED=16'hACE1, DEFAULT_POLY=16'hB400;
  - typedef ent_t (logic [3:0]).
- One sub-module is natural: random_perm_gen_lfsr, which holds the LFSR register, step logic and zero-seed substitution, and outputs lfsr state.
- Swap datapath and pass counter stay in the top.

Test Plan:
- Reset: hold rst=0 -> seq_all==64'hFEDCBA9876543210 immediately, without a clock edge.
- Default SEED, release reset:
  - 1st edge: r=0xE, seq_all==64'hEFDCBA9876543210, lfsr==16'hE270.
  - 2nd edge: r=6, seq_all==64'hE6DCBA987F543210.
- Run 10,000 cycles -> every cycle all 16 nibbles are distinct; j visits 15..1 cyclically with period 15.
- Assert rst=0 mid-pass (e.g. cycle 37) -> seq_all returns to identity asynchronously. After release, cycles 1-2 reproduce the values above.
- SEED=0 -> identical trace to SEED=16'hACE1.
- With RANDOM_PERM_GEN_SNAPSHOT_EN: seq_all stays at identity for edges 1-14, changes on edge 15, then only on edges 30, 45, ...
